// File: rtl/eb_downsizer_if.sv
// Req/ack stream bundle used on both sides of the downsizer.
// The master drives req/data/last; the slave answers with ack.
interface eb_downsizer_if #(
    parameter int W = 8
);
    logic         req;
    logic         ack;
    logic         last;
    logic [W-1:0] data;

    modport master (output req, output data, output last, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/eb_downsizer.sv
// Wide-to-narrow serializer: one RATIO*WIDTH word in, RATIO beats of WIDTH out,
// with the final beat flagged. Optional comb ack bypass gives back-to-back words.
module eb_downsizer #(
    parameter int WIDTH      = 8,
    parameter int RATIO      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit ACK_BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    eb_downsizer_if.slave  t_0,
    eb_downsizer_if.master i_0
);
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RATIO*WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]       sel;
    logic                   busy;
    logic                   last;

    assign busy = (state_q == BUSY);
    assign last = busy && (cnt_q == LAST_IDX);
    assign sel  = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);

    assign i_0.req  = busy;
    assign i_0.last = last;
    assign i_0.data = hold_q[int'(sel) * WIDTH +: WIDTH];

    // The bypass lets a new word land in the same edge the last beat leaves.
    generate
        if (ACK_BYPASS) begin : g_ack_byp
            assign t_0.ack = !busy || (i_0.ack && last);
        end else begin : g_ack_reg
            assign t_0.ack = !busy;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            EMPTY: begin
                if (t_0.req) begin
                    hold_d  = t_0.data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_0.ack) begin
                    if (!last) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (ACK_BYPASS && t_0.req) begin
                        hold_d = t_0.data;
                        cnt_d  = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: tb/tb_eb_downsizer.sv
// Directed and random bench for eb_downsizer across three configurations,
// with a per-instance scoreboard of expected beats.
module tb_eb_downsizer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // A: R4 LSB-first bypass; B: R4 MSB-first no bypass; C: R1 bypass
    eb_downsizer_if #(.W(32)) tA ();
    eb_downsizer_if #(.W(8))  iA ();
    eb_downsizer_if #(.W(32)) tB ();
    eb_downsizer_if #(.W(8))  iB ();
    eb_downsizer_if #(.W(8))  tC ();
    eb_downsizer_if #(.W(8))  iC ();

    eb_downsizer #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1'b1), .ACK_BYPASS(1'b1)) uA (
        .clk(clk), .reset_n(reset_n), .t_0(tA), .i_0(iA));
    eb_downsizer #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1'b0), .ACK_BYPASS(1'b0)) uB (
        .clk(clk), .reset_n(reset_n), .t_0(tB), .i_0(iB));
    eb_downsizer #(.WIDTH(8), .RATIO(1), .LSB_FIRST(1'b1), .ACK_BYPASS(1'b1)) uC (
        .clk(clk), .reset_n(reset_n), .t_0(tC), .i_0(iC));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: {last, data} pushed on each word accept, popped on each beat.
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] qc[$];
    int         outC = 0;

    always @(negedge clk) begin : mon_a
        logic [8:0] e;
        if (!reset_n) qa.delete();
        else begin
            if (iA.req && iA.ack) begin
                check("A_sb_pending", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check("A_sb_beat", 32'({iA.last, iA.data}), 32'(e));
                end
            end
            if (tA.req && tA.ack)
                for (int k = 0; k < 4; k++) qa.push_back({k == 3, tA.data[8*k +: 8]});
        end
    end

    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        if (!reset_n) qb.delete();
        else begin
            if (iB.req && iB.ack) begin
                check("B_sb_pending", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check("B_sb_beat", 32'({iB.last, iB.data}), 32'(e));
                end
            end
            if (tB.req && tB.ack)
                for (int k = 0; k < 4; k++) qb.push_back({k == 3, tB.data[8*(3-k) +: 8]});
        end
    end

    always @(negedge clk) begin : mon_c
        logic [8:0] e;
        if (!reset_n) qc.delete();
        else begin
            if (iC.req && iC.ack) begin
                outC++;
                check("C_sb_pending", 32'(qc.size() != 0), 32'd1);
                if (qc.size() != 0) begin
                    e = qc.pop_front();
                    check("C_sb_beat", 32'({iC.last, iC.data}), 32'(e));
                end
            end
            if (tC.req && tC.ack) qc.push_back({1'b1, tC.data});
        end
    end

    initial begin : stim
        logic [31:0] w;
        int          sent;
        int          cyc;
        tA.req = 0; tA.data = '0; tA.last = 0; iA.ack = 0;
        tB.req = 0; tB.data = '0; tB.last = 0; iB.ack = 0;
        tC.req = 0; tC.data = '0; tC.last = 0; iC.ack = 0;

        // Reset state
        tick();
        tick();
        check("rst_A_req",  32'(iA.req),  32'd0);
        check("rst_A_last", 32'(iA.last), 32'd0);
        check("rst_A_data", 32'(iA.data), 32'd0);
        check("rst_A_tack", 32'(tA.ack),  32'd1);
        check("rst_B_req",  32'(iB.req),  32'd0);
        check("rst_B_tack", 32'(tB.ack),  32'd1);
        reset_n = 1'b1;
        tick();

        // Single word, LSB first, ack tied high
        w = 32'hDDCCBBAA;
        iA.ack = 1; tA.data = w; tA.req = 1;
        check("A1_tack_idle", 32'(tA.ack), 32'd1);
        tick();
        tA.req = 0;
        for (int k = 0; k < 4; k++) begin
            check("A1_req",  32'(iA.req),  32'd1);
            check("A1_data", 32'(iA.data), 32'(w[8*k +: 8]));
            check("A1_last", 32'(iA.last), 32'(k == 3));
            tick();
        end
        check("A1_done_req", 32'(iA.req), 32'd0);

        // Single word, MSB first
        iB.ack = 1; tB.data = w; tB.req = 1;
        tick();
        tB.req = 0;
        for (int k = 0; k < 4; k++) begin
            check("B1_data", 32'(iB.data), 32'(w[8*(3-k) +: 8]));
            check("B1_last", 32'(iB.last), 32'(k == 3));
            tick();
        end
        check("B1_done_req", 32'(iB.req), 32'd0);

        // Back-to-back words with bypass: 8 beats, no gap
        tA.data = 32'h03020100; tA.req = 1;
        tick();
        tA.data = 32'h07060504;
        for (int k = 0; k < 8; k++) begin
            check("A2_req",  32'(iA.req),  32'd1);
            check("A2_data", 32'(iA.data), 32'(k));
            check("A2_last", 32'(iA.last), 32'(k == 3 || k == 7));
            check("A2_tack", 32'(tA.ack),  32'(k == 3 || k == 7));
            tick();
            if (k == 3) tA.req = 0;
        end
        check("A2_done_req", 32'(iA.req), 32'd0);

        // Back-to-back without bypass: one idle cycle between words
        tB.data = 32'h03020100; tB.req = 1;
        tick();
        tB.data = 32'h07060504;
        for (int c = 0; c < 9; c++) begin
            check("B2_req",  32'(iB.req), 32'(c != 4));
            check("B2_tack", 32'(tB.ack), 32'(c == 4));
            if (c != 4) check("B2_data", 32'(iB.data), (c < 4) ? 32'(3 - c) : 32'(12 - c));
            tick();
            if (c == 4) tB.req = 0;
        end
        check("B2_done_req", 32'(iB.req), 32'd0);

        // Downstream stall on beat 1
        tA.data = w; tA.req = 1;
        tick();
        tA.req = 0;
        check("A3_beat0", 32'(iA.data), 32'hAA);
        tick();
        iA.ack = 0;
        for (int k = 0; k < 3; k++) begin
            check("A3_stall_data", 32'(iA.data), 32'hBB);
            check("A3_stall_last", 32'(iA.last), 32'd0);
            check("A3_stall_req",  32'(iA.req),  32'd1);
            check("A3_stall_tack", 32'(tA.ack),  32'd0);
            tick();
        end
        iA.ack = 1;
        check("A3_resume_bb", 32'(iA.data), 32'hBB);
        tick();
        check("A3_resume_cc", 32'(iA.data), 32'hCC);
        tick();
        check("A3_resume_dd", 32'(iA.data), 32'hDD);
        check("A3_resume_last", 32'(iA.last), 32'd1);
        tick();
        check("A3_done_req", 32'(iA.req), 32'd0);

        // Async reset mid-word with cnt=2
        tA.data = w; tA.req = 1;
        tick();
        tA.req = 0;
        tick();
        tick();
        check("R_pre_data", 32'(iA.data), 32'hCC);
        #2 reset_n = 1'b0;
        #1;
        check("R_async_req",  32'(iA.req), 32'd0);
        check("R_async_tack", 32'(tA.ack), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("R_post_req", 32'(iA.req), 32'd0);
        end

        // RATIO=1, random req/ack, 200 words
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 5000) begin
            iC.ack  = ($urandom_range(0, 3) != 0);
            tC.req  = ($urandom_range(0, 3) != 0);
            tC.data = 8'($urandom);
            #1;
            if (tC.req && tC.ack) sent++;
            if (iC.req) check("C_last_with_req", 32'(iC.last), 32'd1);
            @(posedge clk);
            #1;
            cyc++;
        end
        tC.req = 0;
        iC.ack = 1;
        check("C_words_in", 32'(sent), 32'd200);
        cyc = 0;
        while (iC.req && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        check("C_beats_out", 32'(outC), 32'd200);
        check("A_sb_drained", 32'(qa.size()), 32'd0);
        check("B_sb_drained", 32'(qb.size()), 32'd0);
        check("C_sb_drained", 32'(qc.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
